// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;
   import memory_map::*;

   typedef enum logic [1:0] {
      RSP_IDLE = 2'd0,
      RSP_WAIT = 2'd1,
      RSP_RESP = 2'd2
   } dmem_rsp_state_t;

   localparam int unsigned CNT_W = $clog2(16);

   // Byte offset into the DRAM window; addresses below the base wrap high.
   function automatic logic [31:0] dram_offset(input logic [31:0] addr);
      return addr - DRAM_BASE;
   endfunction
endpackage

// File: rtl/memory_map.sv
// SoC address map shared by the core, the interconnect glue and the memory responders.
package memory_map;
   localparam logic [31:0] DRAM_BASE = 32'h8000_0000;
endpackage

// File: rtl/dmem_responder_if.sv
// Core data-memory load/store handshake; the core is the master, the memory is the slave.
interface dmem_responder_if;
   logic [31:0] address;
   logic        read_enable;
   logic [31:0] read_data;
   logic        read_valid;
   logic [31:0] write_data;
   logic        write_enable;
   logic [3:0]  strb;
   logic        write_ready;
   logic        access_fault;

   modport master (
      output address, read_enable, write_data, write_enable, strb,
      input  read_data, read_valid, write_ready, access_fault
   );

   modport slave (
      input  address, read_enable, write_data, write_enable, strb,
      output read_data, read_valid, write_ready, access_fault
   );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered, read-first read port.
module dmem_ram #(
   parameter int unsigned DEPTH_WORDS = 16384,
   parameter int unsigned ADDR_W      = 14,
   parameter string       INIT_FILE   = ""
) (
   input  logic              clock,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              rd_en_i,
   input  logic              wr_en_i,
   input  logic [3:0]        be_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);
   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Read returns the word as it was before a same-edge write.
   always_ff @(posedge clock) begin
      if (rd_en_i) begin
         rdata_q <= mem_q[addr_i];
      end
      if (wr_en_i) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
               mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one core load/store at a time, answers after LATENCY cycles,
// backs the DRAM window with dmem_ram and flags accesses outside the window.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 16384,
   parameter int unsigned LATENCY     = 2,
   parameter string       INIT_FILE   = ""
) (
   input  logic            clock,
   input  logic            reset,
   dmem_responder_if.slave bus
);
   localparam int unsigned      AW           = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0]      WINDOW_BYTES = 32'(4 * DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD     = CNT_W'(LATENCY - 1);

   dmem_rsp_state_t  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec_s;
   logic [AW-1:0]    word_q, word_d, word_s;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       strb_q, strb_d;
   logic             rd_q, rd_d, wr_q, wr_d;
   logic             in_range_q, in_range_d, in_range_s;
   logic             rdata_ok_q, rdata_ok_d;
   logic [31:0]      offset_s, ram_rdata_s;
   logic             req_s, fire_s, resp_s, ram_rd_s, ram_wr_s;

   assign offset_s   = dram_offset(bus.address);
   assign in_range_s = (offset_s < WINDOW_BYTES);
   assign word_s     = offset_s[AW+1:2];
   assign req_s      = bus.read_enable | bus.write_enable;
   assign cnt_dec_s  = cnt_q - CNT_W'(1);

   // Next-state, capture and RAM-strobe decode; the accept cycle counts as the first latency cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      wdata_d    = wdata_q;
      strb_d     = strb_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      in_range_d = in_range_q;
      fire_s     = 1'b0;
      case (state_q)
         RSP_IDLE: begin
            if (req_s) begin
               word_d     = word_s;
               wdata_d    = bus.write_data;
               strb_d     = bus.strb;
               rd_d       = bus.read_enable;
               wr_d       = bus.write_enable;
               in_range_d = in_range_s;
               cnt_d      = CNT_LOAD;
               if (LATENCY == 1) begin
                  state_d = RSP_RESP;
                  fire_s  = 1'b1;
               end else begin
                  state_d = RSP_WAIT;
               end
            end else begin
               state_d = RSP_IDLE;
            end
         end
         RSP_WAIT: begin
            if (!req_s) begin
               state_d = RSP_IDLE;
            end else if (cnt_dec_s == {CNT_W{1'b0}}) begin
               cnt_d   = cnt_dec_s;
               state_d = RSP_RESP;
               fire_s  = 1'b1;
            end else begin
               cnt_d = cnt_dec_s;
            end
         end
         RSP_RESP: state_d = RSP_IDLE;
         default:  state_d = RSP_IDLE;
      endcase
   end

   // The _d capture values already select live inputs (accept edge) or held values (WAIT).
   assign ram_rd_s   = fire_s & rd_d & in_range_d;
   assign ram_wr_s   = fire_s & wr_d & in_range_d;
   assign rdata_ok_d = fire_s ? (rd_d & in_range_d) : rdata_ok_q;

   // State, counter and transaction capture registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= RSP_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         word_q     <= {AW{1'b0}};
         wdata_q    <= 32'h0;
         strb_q     <= 4'h0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         in_range_q <= 1'b0;
         rdata_ok_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         wdata_q    <= wdata_d;
         strb_q     <= strb_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         in_range_q <= in_range_d;
         rdata_ok_q <= rdata_ok_d;
      end
   end

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (AW),
      .INIT_FILE   (INIT_FILE)
   ) u_ram (
      .clock   (clock),
      .addr_i  (word_d),
      .rd_en_i (ram_rd_s),
      .wr_en_i (ram_wr_s),
      .be_i    (strb_d),
      .wdata_i (wdata_d),
      .rdata_o (ram_rdata_s)
   );

   assign resp_s           = (state_q == RSP_RESP);
   assign bus.read_valid   = resp_s & rd_q;
   assign bus.write_ready  = resp_s & wr_q;
   assign bus.access_fault = resp_s & ~in_range_q;
   assign bus.read_data    = rdata_ok_q ? ram_rdata_s : 32'h0;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance for directed/random traffic,
// LATENCY=1 instance for back-to-back reads; expectations come from a word-array model.
`timescale 1ns/1ps
module tb_dmem_responder;
   import memory_map::*;

   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] WIN   = 32'(4 * DEPTH);

   typedef struct {
      bit          rd;
      bit          wr;
      bit          fault;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t qa[$];
   exp_t qb[$];
   logic [31:0] mem_a [DEPTH];
   logic [31:0] mem_b [DEPTH];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   dmem_responder_if ifa();
   dmem_responder_if ifb();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .INIT_FILE("")) dut_a (
      .clock(clock), .reset(reset), .bus(ifa));
   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .INIT_FILE("")) dut_b (
      .clock(clock), .reset(reset), .bus(ifb));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input bit b, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st);
      if (b) begin
         ifb.read_enable = rd; ifb.write_enable = wr; ifb.address = addr;
         ifb.write_data = wd; ifb.strb = st;
      end else begin
         ifa.read_enable = rd; ifa.write_enable = wr; ifa.address = addr;
         ifa.write_data = wd; ifa.strb = st;
      end
   endtask

   // Reference: a window of DEPTH words; reads see the word before any same-request write.
   task automatic model(input bit b, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st, output exp_t e);
      logic [31:0] off;
      logic [31:0] w;
      int          idx;
      off     = addr - DRAM_BASE;
      e.rd    = rd;
      e.wr    = wr;
      e.fault = (off >= WIN);
      e.data  = 32'h0;
      e.cyc   = 0;
      if (!e.fault) begin
         idx = int'(off / 32'd4);
         w   = b ? mem_b[idx] : mem_a[idx];
         if (rd) e.data = w;
         if (wr) begin
            for (int i = 0; i < 4; i++) if (st[i]) w[8*i +: 8] = wd[8*i +: 8];
            if (b) mem_b[idx] = w; else mem_a[idx] = w;
         end
      end
   endtask

   // Issue one request (called just after a rising edge), wait for its pulse, end just after
   // the response edge with the request still driven so the caller can chain or drop it.
   task automatic do_req(input bit b, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st,
                         output logic [31:0] rdata, output int pcyc);
      exp_t e;
      bit   seen;
      drive(b, rd, wr, addr, wd, st);
      model(b, rd, wr, addr, wd, st, e);
      e.cyc = cyc + (b ? 1 : 2);
      if (b) qb.push_back(e); else qa.push_back(e);
      seen  = 1'b0;
      rdata = 32'h0;
      pcyc  = -1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clock);
         if (b ? (ifb.read_valid | ifb.write_ready) : (ifa.read_valid | ifa.write_ready)) begin
            seen  = 1'b1;
            rdata = b ? ifb.read_data : ifa.read_data;
            pcyc  = cyc;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: dut%0d no response for addr %h", b, addr);
         if (b) void'(qb.pop_back()); else void'(qa.pop_back());
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input bit b);
      drive(b, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   // Monitor: every response pulse is matched against the oldest expectation for that DUT.
   always @(negedge clock) begin
      if (!reset) begin
         for (int b = 0; b < 2; b++) begin
            logic        rv, wrdy, fl;
            logic [31:0] rdv;
            exp_t        e;
            rv   = b ? ifb.read_valid   : ifa.read_valid;
            wrdy = b ? ifb.write_ready  : ifa.write_ready;
            fl   = b ? ifb.access_fault : ifa.access_fault;
            rdv  = b ? ifb.read_data    : ifa.read_data;
            if (rv || wrdy) begin
               if ((b ? qb.size() : qa.size()) == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_resp: dut%0d pulse rv=%0b wr=%0b with nothing pending", b, rv, wrdy);
               end else begin
                  if (b) e = qb.pop_front(); else e = qa.pop_front();
                  check("read_valid", 32'(rv), 32'(e.rd));
                  check("write_ready", 32'(wrdy), 32'(e.wr));
                  check("access_fault", 32'(fl), 32'(e.fault));
                  check("resp_cycle", cyc, e.cyc);
                  if (e.rd) check("read_data", rdv, e.data);
               end
            end else if (fl) begin
               check("fault_without_pulse", 32'(fl), 32'h0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd_w, a;
      logic [31:0] exp_w;
      int          pc, prev_pc, k;
      reset = 1'b1;
      idle(1'b0);
      idle(1'b1);
      repeat (3) @(negedge clock);
      check("rst_read_valid_a", 32'(ifa.read_valid), 32'h0);
      check("rst_write_ready_a", 32'(ifa.write_ready), 32'h0);
      check("rst_fault_a", 32'(ifa.access_fault), 32'h0);
      check("rst_read_data_a", ifa.read_data, 32'h0);
      check("rst_read_valid_b", 32'(ifb.read_valid), 32'h0);
      check("rst_read_data_b", ifb.read_data, 32'h0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Fill the working set, including the last word of the window.
      for (int i = 0; i < 16; i++) do_req(1'b0, 1'b0, 1'b1, DRAM_BASE + 32'(4*i), $urandom, 4'hF, rd_w, pc);
      do_req(1'b0, 1'b0, 1'b1, DRAM_BASE + WIN - 32'd4, 32'h5A5A_0FF0, 4'hF, rd_w, pc);
      idle(1'b0);
      @(posedge clock); #1;

      do_req(1'b0, 1'b0, 1'b1, DRAM_BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, rd_w, pc);
      do_req(1'b0, 1'b1, 1'b0, DRAM_BASE + 32'd8, 32'h0, 4'h0, rd_w, pc);
      check("deadbeef_readback", rd_w, 32'hDEAD_BEEF);

      do_req(1'b0, 1'b0, 1'b1, DRAM_BASE + 32'd20, 32'h1122_3344, 4'hF, rd_w, pc);
      do_req(1'b0, 1'b0, 1'b1, DRAM_BASE + 32'd20, 32'h0000_AA00, 4'b0010, rd_w, pc);
      do_req(1'b0, 1'b1, 1'b0, DRAM_BASE + 32'd20, 32'h0, 4'h0, rd_w, pc);
      check("partial_lane1", rd_w, 32'h1122_AA44);

      do_req(1'b0, 1'b1, 1'b0, DRAM_BASE - 32'd4, 32'h0, 4'h0, rd_w, pc);
      check("fault_read_data", rd_w, 32'h0);
      do_req(1'b0, 1'b0, 1'b1, DRAM_BASE + WIN, 32'hA5A5_A5A5, 4'hF, rd_w, pc);
      do_req(1'b0, 1'b1, 1'b0, DRAM_BASE, 32'h0, 4'h0, rd_w, pc);
      do_req(1'b0, 1'b1, 1'b0, DRAM_BASE + WIN - 32'd4, 32'h0, 4'h0, rd_w, pc);
      check("last_word_kept", rd_w, 32'h5A5A_0FF0);

      do_req(1'b0, 1'b0, 1'b1, DRAM_BASE + 32'd12, 32'hFFFF_FFFF, 4'h0, rd_w, pc);
      do_req(1'b0, 1'b1, 1'b0, DRAM_BASE + 32'd12, 32'h0, 4'h0, rd_w, pc);

      // Both enables: write handshake plus pre-write read data, then the new word.
      do_req(1'b0, 1'b1, 1'b1, DRAM_BASE + 32'd28, 32'h7777_1234, 4'hF, rd_w, pc);
      do_req(1'b0, 1'b1, 1'b0, DRAM_BASE + 32'd28, 32'h0, 4'h0, rd_w, pc);
      check("both_then_read", rd_w, 32'h7777_1234);

      // Abort: request withdrawn during WAIT.
      drive(1'b0, 1'b0, 1'b1, DRAM_BASE + 32'd36, 32'hCAFE_F00D, 4'hF);
      @(posedge clock); #1;
      idle(1'b0);
      repeat (3) @(posedge clock);
      #1;
      do_req(1'b0, 1'b1, 1'b0, DRAM_BASE + 32'd36, 32'h0, 4'h0, rd_w, pc);

      // Reset asserted between edges while a write waits.
      drive(1'b0, 1'b0, 1'b1, DRAM_BASE + 32'd40, 32'h0BAD_C0DE, 4'hF);
      @(posedge clock); #2;
      reset = 1'b1;
      #1;
      check("midrst_read_valid", 32'(ifa.read_valid), 32'h0);
      check("midrst_write_ready", 32'(ifa.write_ready), 32'h0);
      check("midrst_fault", 32'(ifa.access_fault), 32'h0);
      check("midrst_read_data", ifa.read_data, 32'h0);
      idle(1'b0);
      @(negedge clock); @(posedge clock); @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      do_req(1'b0, 1'b1, 1'b0, DRAM_BASE + 32'd40, 32'h0, 4'h0, rd_w, pc);

      // Randomised traffic over the working set plus out-of-window addresses.
      for (int n = 0; n < 60; n++) begin
         k = $urandom_range(0, 9);
         if (k < 8)       a = DRAM_BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         else if (k == 8) a = DRAM_BASE - 32'(4 * $urandom_range(1, 8));
         else             a = $urandom & 32'h7FFF_FFFF;
         k = $urandom_range(0, 19);
         do_req(1'b0, (k == 0) || (k >= 10), (k < 10), a, $urandom, 4'($urandom_range(0, 15)), rd_w, pc);
         if ($urandom_range(0, 3) == 0) begin
            idle(1'b0);
            @(posedge clock); #1;
         end
      end
      idle(1'b0);

      // LATENCY=1 instance: held reads to words 0..3 complete every second cycle.
      for (int i = 0; i < 4; i++)
         do_req(1'b1, 1'b0, 1'b1, DRAM_BASE + 32'(4*i), 32'h1000_0000 + 32'(i) * 32'h111, 4'hF, rd_w, pc);
      prev_pc = 0;
      for (int i = 0; i < 4; i++) begin
         do_req(1'b1, 1'b1, 1'b0, DRAM_BASE + 32'(4*i), 32'h0, 4'h0, rd_w, pc);
         exp_w = 32'h1000_0000 + 32'(i) * 32'h111;
         check("b2b_data", rd_w, exp_w);
         if (i > 0) check("b2b_spacing", pc - prev_pc, 32'd2);
         prev_pc = pc;
      end
      idle(1'b1);
      repeat (4) @(posedge clock);
      @(negedge clock);
      check("queue_a_drained", qa.size(), 32'h0);
      check("queue_b_drained", qb.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
